hex_display_scanner: RTL and testbench

//  Time-multiplexes one shared hex_to_7seg decoder across NUM_DIGITS common-anode/cathode digits.

---
 rtl/hex_display_scanner_if.sv | 23 ++
 rtl/hex_display_scanner.sv | 106 ++++++++++
 tb/tb_hex_display_scanner.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hex_display_scanner_if.sv
// Display-side signal bundle for the hex digit scanner: value/strobe inputs and
// the shared-decoder nibble plus per-digit enables going back out.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      load;
    logic                      lz_suppress;
    logic [3:0]                hex_out;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      frame_tick;

    modport master (
        output enable, value, load, lz_suppress,
        input  hex_out, digit_en, frame_tick
    );

    modport slave (
        input  enable, value, load, lz_suppress,
        output hex_out, digit_en, frame_tick
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Round-robin scanner feeding one shared hex_to_7seg decoder, with a blanking
// guard at the start of every digit slot and frame-coherent value updates.
//
//  state | meaning
//  IDLE  | scanning stopped, all digits dark, active follows pending
//  BLANK | first BLANK_CYCLES of a slot, nibble presented, no digit enabled
//  SHOW  | rest of the slot, current digit enabled unless suppressed
module hex_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst,
    hex_display_scanner_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] SHOW_CNT = CNT_W'(BLANK_CYCLES);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d;
    logic [3:0]                hex_q, hex_d;
    logic [NUM_DIGITS-1:0]     en_q, en_d;
    logic                      tick_q, tick_d;
    logic                      suppress_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            hex_q     <= '0;
            en_q      <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            hex_q     <= hex_d;
            en_q      <= en_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        pending_d = bus.load ? bus.value : pending_q;
        active_d  = active_q;

        if (!bus.enable) begin
            state_d  = IDLE;
            idx_d    = '0;
            cnt_d    = '0;
            active_d = pending_d;
        end else if (state_q == IDLE) begin
            state_d  = BLANK;
            idx_d    = '0;
            cnt_d    = '0;
            active_d = pending_d;
            tick_d   = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == LAST_IDX) begin
                // Frame boundary: the only place a scanning display picks up new data.
                idx_d    = '0;
                active_d = pending_d;
                tick_d   = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d >= SHOW_CNT) ? SHOW : BLANK;
        end
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        suppress_d = bus.lz_suppress && (idx_d != '0) &&
                     ((active_d >> (4 * idx_d)) == '0);
        hex_d      = (state_d == IDLE) ? 4'h0 : active_d[4*idx_d +: 4];
        en_d       = '0;
        if (state_d == SHOW && !suppress_d)
            en_d = NUM_DIGITS'(1) << idx_d;
    end

    assign bus.hex_out    = hex_q;
    assign bus.digit_en   = en_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: whole-frame expectation table plus
// hand-written disable/reset sequences.
module tb_hex_display_scanner;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hex_display_scanner_if #(.NUM_DIGITS(4)) bus ();

    hex_display_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          load_at;   // frame cycle whose closing edge captures load_val, -1 = none
        logic [15:0] load_val;
        logic        lz;
        logic [15:0] hex;       // expected nibble per slot, slot k at [4k+:4]
        logic [3:0]  mask;      // slots whose digit is expected to light
    } frame_t;

    frame_t tbl [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        int s;
        int c;
        logic [3:0] exp_en;

        checks = 0;
        errors = 0;

        tbl[0] = '{-1, 16'h0000, 1'b0, 16'h3A5F, 4'b1111};
        tbl[1] = '{19, 16'h1234, 1'b0, 16'h3A5F, 4'b1111};
        tbl[2] = '{31, 16'hBEEF, 1'b0, 16'h1234, 4'b1111};
        tbl[3] = '{31, 16'h00C0, 1'b0, 16'hBEEF, 4'b1111};
        tbl[4] = '{31, 16'h0000, 1'b1, 16'h00C0, 4'b0011};
        tbl[5] = '{-1, 16'h0000, 1'b1, 16'h0000, 4'b0001};

        rst             = 1'b1;
        bus.enable      = 1'b0;
        bus.load        = 1'b0;
        bus.value       = 16'h0000;
        bus.lz_suppress = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset%0d hex", i), 16'(bus.hex_out), 16'h0);
            chk($sformatf("reset%0d en", i), 16'(bus.digit_en), 16'h0);
            chk($sformatf("reset%0d tick", i), 16'(bus.frame_tick), 16'h0);
        end
        rst = 1'b0;
        step();
        chk("idle en", 16'(bus.digit_en), 16'h0);
        chk("idle tick", 16'(bus.frame_tick), 16'h0);

        bus.value  = 16'h3A5F;
        bus.load   = 1'b1;
        bus.enable = 1'b1;
        step();
        bus.load = 1'b0;

        for (int r = 0; r < 6; r++) begin
            bus.lz_suppress = tbl[r].lz;
            for (int cyc = 0; cyc < 32; cyc++) begin
                s = cyc / 8;
                c = cyc % 8;
                exp_en = (c >= 2 && tbl[r].mask[s]) ? (4'b0001 << s) : 4'b0000;
                chk($sformatf("r%0d c%0d en", r, cyc), 16'(bus.digit_en), 16'(exp_en));
                chk($sformatf("r%0d c%0d hex", r, cyc), 16'(bus.hex_out), 16'(tbl[r].hex[4*s +: 4]));
                chk($sformatf("r%0d c%0d tick", r, cyc), 16'(bus.frame_tick), (cyc == 0) ? 16'h1 : 16'h0);
                if (cyc == tbl[r].load_at) begin
                    bus.load  = 1'b1;
                    bus.value = tbl[r].load_val;
                end
                step();
                bus.load = 1'b0;
            end
        end

        // Disable in the 4th SHOW cycle of digit 1, then re-enable.
        bus.lz_suppress = 1'b0;
        for (int i = 0; i < 13; i++) step();
        chk("dis pre en", 16'(bus.digit_en), 16'h2);
        chk("dis pre hex", 16'(bus.hex_out), 16'h0);
        bus.enable = 1'b0;
        bus.value  = 16'h5678;
        bus.load   = 1'b1;
        step();
        bus.load = 1'b0;
        chk("dis en", 16'(bus.digit_en), 16'h0);
        chk("dis tick", 16'(bus.frame_tick), 16'h0);
        step();
        chk("dis hold en", 16'(bus.digit_en), 16'h0);
        bus.enable = 1'b1;
        step();
        chk("reen tick", 16'(bus.frame_tick), 16'h1);
        chk("reen en", 16'(bus.digit_en), 16'h0);
        chk("reen hex", 16'(bus.hex_out), 16'h8);
        step();
        step();
        chk("reen show en", 16'(bus.digit_en), 16'h1);
        chk("reen show hex", 16'(bus.hex_out), 16'h8);
        chk("reen show tick", 16'(bus.frame_tick), 16'h0);

        // Reset in the middle of SHOW.
        step();
        step();
        chk("prerst en", 16'(bus.digit_en), 16'h1);
        rst = 1'b1;
        step();
        chk("midrst hex", 16'(bus.hex_out), 16'h0);
        chk("midrst en", 16'(bus.digit_en), 16'h0);
        chk("midrst tick", 16'(bus.frame_tick), 16'h0);
        rst = 1'b0;
        step();
        chk("postrst tick", 16'(bus.frame_tick), 16'h1);
        chk("postrst hex", 16'(bus.hex_out), 16'h0);
        step();
        step();
        chk("postrst en", 16'(bus.digit_en), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
